uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serialising UART transmitter that drives the serial line consumed by the team's UART receiver FSM (IDLE/START/DATA/STOP).
- Accepts a parallel word over a valid/ready handshake.
- Emits the frame LSB-first: start bit, data bits, optional parity bit, stop bit(s).
- Each bit lasts CLKS_PER_BIT clock cycles.
- Sits between the system-side byte source and the top-level tx pin.

Parameters:
DATA_BITS, 8, payload width per frame; legal 5..9.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal >= 1.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
tx_data  input  DATA_BITS  word to transmit; sampled only on acceptance.
tx_valid  input  1  source has a word available.
tx_ready  output  1  block can accept a word; high only in IDLE.
tx  output  1  serial line, registered; idle level high.
tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
tx_done  output  1  single-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=1, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame: tx returns to 1 immediately and no tx_done is produced.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is defined in the shared package.
- Acceptance:
  - A word is accepted on a clock edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge; state goes to START.
  - tx_valid while tx_ready=0 is ignored; no queuing.
  - Changes on tx_data after acceptance have no effect.
- Latency: tx goes low on the edge after the acceptance edge, i.e. the first START cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit.
  - The bit ends when the count equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - With CLKS_PER_BIT=1 every cycle is a bit end.
  - Counter width is $clog2(CLKS_PER_BIT), minimum 1.
- START: drive tx=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - Drive tx = shift_reg[0] and shift right at each bit end.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: drive tx = XOR of the latched data, XOR PARITY_ODD, for one bit time.
- STOP:
  - Drive tx=1 for STOP_BITS bit times.
  - In the final cycle of the last stop bit, tx_done=1 and the state returns to IDLE on the next edge.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, counted from the first START cycle to the end of the last stop bit.
- Back-to-back frames:
  - tx_ready is high during the first IDLE cycle after STOP.
  - If tx_valid is held, the next word is accepted there and the next start bit begins one cycle later.
  - The minimum idle-high gap between frames is therefore exactly 1 cycle beyond the stop bits.
- tx_busy equals (state != IDLE), combinational from the state register. tx_ready is its complement.
- Parameter checks: elaboration-time assertion fails on DATA_BITS outside 5..9, STOP_BITS outside 1..2, or CLKS_PER_BIT < 1.

Decomposition:
- Package uart_pkg:
  - typedef enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Function for the counter width.
  - Constants UART_IDLE_LEVEL=1'b1 and UART_START_LEVEL=1'b0, shared with the receiver.
- Sub-module uart_baud_tick:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, clear; output tick, high in the last cycle of each bit.
  - clear is held high in IDLE so every frame starts phase-aligned.
- The FSM, shift register and parity logic stay in uart_tx.

Test Plan:
1. DATA_BITS=8, CLKS_PER_BIT=4, no parity, 1 stop; send 0xA5 -> tx carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; first 0 one cycle after acceptance; tx_done pulses in cycle 40 of the frame; tx_busy high for exactly 40 cycles.
2. PARITY_EN=1: 0xA5 with PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1; 0x01 even -> parity bit 1; frame length 44 cycles.
3. tx_valid held high with 0x3C then 0xC3 -> two frames separated by exactly 1 extra high cycle; the second word is accepted in the IDLE cycle that carries tx_ready=1; tx_data toggled mid-frame does not alter the bits sent.
4. Assert rst low in DATA bit 3 -> tx=1, tx_busy=0, tx_ready=1 asynchronously; no tx_done; after release, a new 0x5A frame is transmitted correctly.
5. CLKS_PER_BIT=1, STOP_BITS=2, DATA_BITS=5; send 5'h15 -> tx sequence 0,1,0,1,0,1,1,1 over 8 cycles; tx_done in the 8th cycle.
6. tx_valid pulsed for one cycle while busy -> ignored, no second frame; tx idles at 1 indefinitely with tx_valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels common to
// the transmitter and the receiver, and the baud counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Width of a counter running 0..clks-1; never narrower than one bit so a
  // divide-by-one counter still has a legal vector.
  function automatic int uart_cnt_width(input int clks);
    return (clks <= 1) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   clear - hold the counter at zero (asserted while the transmitter idles)
//   tick  - high in the last clock cycle of each bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With CLKS_PER_BIT=1 the counter sits at zero and every cycle is a tick.
  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// Serialising UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits, each CLKS_PER_BIT cycles long.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   tx_data  - word to send, sampled when tx_valid && tx_ready
//   tx_valid - source has a word
//   tx_ready - transmitter idle and able to accept
//   tx       - registered serial line, idles high
//   tx_busy  - frame in progress
//   tx_done  - one-cycle pulse in the final cycle of the last stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (CLKS_PER_BIT < 1)) begin : g_bad_params
    $error("uart_tx: illegal parameter set");
  end

  // The bit index counts data bits and, later, stop bits; 4 bits covers 9.
  localparam int            IW        = 4;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          PAR_SENSE = (PARITY_ODD != 0);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_SENSE;
  endfunction

  uart_tx_state_t       state, state_nxt;
  logic [IW-1:0]        bit_idx, bit_idx_nxt;
  logic                 tx_q, tx_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_q;
  logic                 tick;
  logic                 accept;

  assign tx_busy  = (state != IDLE);
  assign tx_ready = !tx_busy;
  assign accept   = tx_valid && tx_ready;
  assign tx       = tx_q;

  // Counter is held cleared while idle so each frame starts phase-aligned.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(tx_ready),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      tx_q    <= tx_nxt;
    end
  end

  // Payload and parity only matter once a word is accepted, so no reset.
  // Parity is captured up front because the shift register is consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= tx_data;
      parity_q  <= parity_of(tx_data);
    end else if ((state == DATA) && tick) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  // tx is registered, so the level for the upcoming bit is chosen on the
  // transition into it: shift_reg[0] when entering DATA, shift_reg[1] when
  // moving on to the next data bit (the shift happens on the same edge).
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx_q;
    tx_done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = START;
          bit_idx_nxt = '0;
          tx_nxt      = UART_START_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_DATA) begin
            bit_idx_nxt = '0;
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              tx_nxt    = parity_q;
            end else begin
              state_nxt = STOP;
              tx_nxt    = UART_IDLE_LEVEL;
            end
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            tx_nxt      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          tx_nxt    = UART_IDLE_LEVEL;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            state_nxt   = IDLE;
            bit_idx_nxt = '0;
            tx_done     = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_idx_nxt = '0;
        tx_nxt      = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx. Four instances cover 8N1, 8E1, 8O1 (4 clocks
// per bit) and 5N2 (1 clock per bit). Stimulus pushes the hand-computed frame
// (bits in line order, first bit leftmost) into a queue; a per-instance
// monitor reassembles each frame from tx and compares on tx_done.
module tb_uart_tx;

  localparam int DB_A [4] = '{8, 8, 8, 5};
  localparam int CPB_A[4] = '{4, 4, 4, 1};
  localparam int PE_A [4] = '{0, 1, 1, 0};
  localparam int PO_A [4] = '{0, 0, 1, 0};
  localparam int SB_A [4] = '{1, 1, 1, 2};

  typedef struct {
    int          id;
    logic [15:0] bits;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [8:0] td     [4];
  logic       tv     [4];
  logic       tx_a   [4];
  logic       busy_a [4];
  logic       ready_a[4];
  logic       done_a [4];

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int DB  = DB_A[i];
    localparam int CPB = CPB_A[i];
    localparam int FL  = (1 + DB + PE_A[i] + SB_A[i]) * CPB;

    int          cyc      = 0;
    logic [15:0] cap      = '0;
    bit          glitch   = 1'b0;
    bit          chk_idle = 1'b0;
    exp_t        e;

    uart_tx #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE_A[i]),
      .PARITY_ODD  (PO_A[i]),
      .STOP_BITS   (SB_A[i])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (td[i][DB-1:0]),
      .tx_valid(tv[i]),
      .tx_ready(ready_a[i]),
      .tx      (tx_a[i]),
      .tx_busy (busy_a[i]),
      .tx_done (done_a[i])
    );

    always @(negedge clk) begin
      if (chk_idle) begin
        chk_idle = 1'b0;
        check($sformatf("post_done_idle[%0d]", i), 32'({busy_a[i], tx_a[i]}), 32'b01);
      end
      if (!rst || !busy_a[i]) begin
        cyc    = 0;
        cap    = '0;
        glitch = 1'b0;
      end else begin
        if ((cyc % CPB) == 0) cap = {cap[14:0], tx_a[i]};
        else if (tx_a[i] !== cap[0]) glitch = 1'b1;
        cyc++;
        if (done_a[i] === 1'b1) begin
          chk_idle = 1'b1;
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame[%0d]: got bits 0x%0h, want no frame", i, cap);
          end else begin
            e = sb.pop_front();
            check($sformatf("frame_inst[%0d]", i), 32'(i), 32'(e.id));
            check($sformatf("frame_bits[%0d]", i), 32'(cap), 32'(e.bits));
            check($sformatf("frame_len[%0d]", i), 32'(cyc), 32'(FL));
            check($sformatf("bit_stable[%0d]", i), 32'(glitch), 32'd0);
          end
        end
      end
    end
  end

  // Issue one word at a negedge; it is accepted on the next posedge.
  task automatic send(input int i, input logic [8:0] d, input logic [15:0] bits,
                      input bit expect_frame);
    exp_t x;
    @(negedge clk);
    check($sformatf("ready_before_accept[%0d]", i), 32'(ready_a[i]), 32'd1);
    td[i] = d;
    tv[i] = 1'b1;
    if (expect_frame) begin
      x.id   = i;
      x.bits = bits;
      sb.push_back(x);
    end
    @(posedge clk);
    #1 tv[i] = 1'b0;
    @(negedge clk);
    check($sformatf("start_latency[%0d]", i), 32'({busy_a[i], tx_a[i]}), 32'b10);
  endtask

  task automatic wait_idle(input int i, input int budget);
    for (int k = 0; k < budget && busy_a[i] === 1'b1; k++) @(negedge clk);
    check($sformatf("idle_timeout[%0d]", i), 32'(busy_a[i]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    exp_t x;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      td[i] = '0;
      tv[i] = 1'b0;
    end
    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx[%0d]", i), 32'(tx_a[i]), 32'd1);
      check($sformatf("rst_busy[%0d]", i), 32'(busy_a[i]), 32'd0);
      check($sformatf("rst_ready[%0d]", i), 32'(ready_a[i]), 32'd1);
      check($sformatf("rst_done[%0d]", i), 32'(done_a[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 8N1, 0xA5
    send(0, 9'h0A5, 16'b0101001011, 1'b1);
    wait_idle(0, 100);

    // 8E1 / 8O1 parity
    send(1, 9'h0A5, 16'b01010010101, 1'b1);
    wait_idle(1, 100);
    send(2, 9'h0A5, 16'b01010010111, 1'b1);
    wait_idle(2, 100);
    send(1, 9'h001, 16'b01000000011, 1'b1);
    wait_idle(1, 100);

    // Back-to-back with tx_valid held, data changed after acceptance
    @(negedge clk);
    check("b2b_ready_first", 32'(ready_a[0]), 32'd1);
    td[0] = 9'h03C;
    tv[0] = 1'b1;
    x.id = 0; x.bits = 16'b0001111001; sb.push_back(x);
    @(posedge clk);
    #1 td[0] = 9'h0C3;
    x.id = 0; x.bits = 16'b0110000111; sb.push_back(x);
    for (int k = 0; k < 60 && done_a[0] !== 1'b1; k++) @(negedge clk);
    check("b2b_done_seen", 32'(done_a[0]), 32'd1);
    check("b2b_ready_in_stop", 32'(ready_a[0]), 32'd0);
    @(negedge clk);
    check("b2b_gap_cycle", 32'({ready_a[0], tx_a[0]}), 32'b11);
    @(posedge clk);
    #1 tv[0] = 1'b0;
    td[0] = 9'h0FF;
    @(negedge clk);
    check("b2b_second_start", 32'({busy_a[0], tx_a[0]}), 32'b10);
    repeat (8) begin
      repeat (3) @(posedge clk);
      #1 td[0] = ~td[0];
    end
    wait_idle(0, 100);

    // Reset in data bit 3 of a 0x00 frame
    send(0, 9'h000, 16'b0, 1'b0);
    repeat (17) @(negedge clk);
    check("pre_abort_tx", 32'({busy_a[0], tx_a[0]}), 32'b10);
    #1 rst = 1'b0;
    #1;
    check("abort_tx", 32'(tx_a[0]), 32'd1);
    check("abort_busy", 32'(busy_a[0]), 32'd0);
    check("abort_ready", 32'(ready_a[0]), 32'd1);
    check("abort_done", 32'(done_a[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send(0, 9'h05A, 16'b0010110101, 1'b1);
    wait_idle(0, 100);

    // 5N2 at one clock per bit
    send(3, 9'h015, 16'b01010111, 1'b1);
    wait_idle(3, 30);

    // Valid pulse while busy is dropped; line then stays idle
    send(0, 9'h081, 16'b0100000011, 1'b1);
    repeat (10) @(negedge clk);
    check("busy_ready_low", 32'(ready_a[0]), 32'd0);
    td[0] = 9'h055;
    tv[0] = 1'b1;
    @(negedge clk);
    tv[0] = 1'b0;
    wait_idle(0, 100);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
